care_scheduler: RTL
===================

// Module: care_scheduler
// PURPOSE
//  Sequences all updates into the pet-stat register block (hunger..social, 6 stats).
//  Divides clk into decay ticks, rotating over stats 0..5 to select which one grows.
//  Round-robin arbitrates pending care requests (buttons, random events) into 1-cycle decrement pulses with cooldown.
//  Never drives a care pulse and a decay tick for the same stat in the same cycle.
//  Sits between input debouncers/LFSR and the stats block; drives its inputs[7:0] and tick/select.
// PARAMETERS
//  TICK_DIV   10_000_000  clk cycles per decay tick (>=4)
//  COOLDOWN   1_000_000   idle cycles enforced after each care pulse (>=1)
//  NUM_STATS  6           stat count; fixed 6 for this build (pointer wraps 5->0)
// PORTS
//  clk          in   1  27 MHz system clock
//  reset        in   1  synchronous, active-high
//  enable       in   1  0 = pause: tick counter holds, no new grants (cooldown still counts)
//  btn_req      in   6  care request per stat, sampled every clk (level or pulse)
//  rnd_valid    in   1  random-event request strobe
//  rnd_stat     in   5  random stat index; only values 0..5 are accepted
//  care_pulse   out  8  one-hot decrement pulse to stats inputs; bits 7:6 always 0
//  decay_tick   out  1  1-cycle growth strobe
//  decay_sel    out  3  stat index for decay_tick, 0..5
//  pending      out  6  sticky request bits awaiting grant
//  busy         out  1  1 in GRANT or COOLDOWN
// BEHAVIOUR
//  Reset: care_pulse=0, decay_tick=0, decay_sel=0, pending=0, busy=0, tick_cnt=0, cd_cnt=0, rr_ptr=0, state=IDLE.
//  All outputs are registered.
//  Tick divider:
//   - With enable=1, tick_cnt counts 0..TICK_DIV-1.
//   - On the edge where tick_cnt==TICK_DIV-1: tick_cnt->0, decay_tick=1 for one cycle, decay_sel=nxt_sel.
//   - nxt_sel advances 0,1,..,5,0 after each tick. First tick after reset has decay_sel=0.
//   - With enable=0, tick_cnt holds.
//  Pending:
//   - pending[i] sets on btn_req[i]=1.
//   - pending[rnd_stat] sets on rnd_valid=1 when rnd_stat<6; rnd_stat>=6 is ignored.
//   - Requests for an already-pending stat merge (no count).
//   - A bit clears on the edge its grant issues.
//   - Set wins over clear if the same bit is requested on its grant edge; pending stays 1.
//  FSM IDLE/GRANT/COOLDOWN:
//   - IDLE: if enable and pending!=0, select the first set bit searching rr_ptr, rr_ptr+1, ... mod 6.
//     Collision rule: if this edge also fires a tick (tick_cnt==TICK_DIV-1) and sel==nxt_sel,
//     hold one cycle in IDLE (rr_ptr unchanged). Otherwise go to GRANT:
//     care_pulse[sel]=1, pending[sel] cleared, rr_ptr=(sel+1) mod 6.
//   - GRANT (1 cycle): care_pulse=0, cd_cnt=COOLDOWN-1, go to COOLDOWN.
//   - COOLDOWN: cd_cnt decrements; at 0 go to IDLE.
//  Latency:
//   - btn_req high at edge N -> pending at N; care_pulse high in the cycle after edge N+1 (2 cycles), if IDLE and no collision.
//   - Back-to-back grant spacing is COOLDOWN+2 cycles.
//  enable drop mid-COOLDOWN: finish cooldown, then wait in IDLE. A pulse already in GRANT always completes.
//  reset mid-operation: everything returns to reset values next edge; pending is lost.
//  Invariants:
//   - care_pulse is zero or one-hot in bits 5:0.
//   - Never (decay_tick && care_pulse[decay_sel]).
// STRUCTURE
//  tama_pkg:
//   - NUM_STATS=6
//   - STAT_HUNGER=0, STAT_HAPPY=1, STAT_HEALTH=2, STAT_HYGIENE=3, STAT_ENERGY=4, STAT_SOCIAL=5
//   - state encoding IDLE=0, GRANT=1, COOLDOWN=2
//  Sub-module rr_arbiter6: combinational first-set search from pointer; outputs sel[2:0] and any.
//  Tick divider and FSM stay inline.
// TESTING (TICK_DIV=8, COOLDOWN=3)
//  1. Reset, enable=1, no requests:
//     decay_tick every 8 cycles, decay_sel 0,1,2,3,4,5,0; care_pulse stays 0.
//  2. btn_req=6'b000100 for 1 cycle:
//     pending=000100 next cycle; care_pulse=8'h04 exactly 1 cycle, 2 cycles after request;
//     busy high 4 cycles.
//  3. btn_req=6'b111111 held 1 cycle:
//     grants in order 0,1,2,3,4,5, spaced 5 cycles apart; pending ends 0.
//  4. Collision: request stat 2 timed so the grant edge coincides with the tick with nxt_sel=2:
//     grant delayed 1 cycle; never decay_tick && care_pulse[2].
//  5. rnd_valid with rnd_stat=7 -> pending unchanged; rnd_stat=5 -> care_pulse=8'h20.
//  6. Assert reset mid-COOLDOWN with pending=000011:
//     next cycle all outputs 0, state IDLE, decay_sel=0; the next decay tick comes 8 cycles later.

Source files
------------

// File: rtl/care_scheduler_pkg.sv
// Shared constants, stat indices and helpers for the pet-stat care scheduler.
// Stat index arithmetic always wraps at NUM_STATS.
package care_scheduler_pkg;

    localparam int NUM_STATS = 6;

    localparam logic [2:0] STAT_HUNGER  = 3'd0;
    localparam logic [2:0] STAT_HAPPY   = 3'd1;
    localparam logic [2:0] STAT_HEALTH  = 3'd2;
    localparam logic [2:0] STAT_HYGIENE = 3'd3;
    localparam logic [2:0] STAT_ENERGY  = 3'd4;
    localparam logic [2:0] STAT_SOCIAL  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT    = 2'd1,
        ST_COOLDOWN = 2'd2
    } sched_state_e;

    function automatic logic [2:0] stat_inc(input logic [2:0] s);
        return (s == STAT_SOCIAL) ? STAT_HUNGER : s + 3'd1;
    endfunction

    function automatic logic [NUM_STATS-1:0] stat_onehot(input logic [2:0] s);
        logic [NUM_STATS-1:0] v;
        v = '0;
        if (s < 3'(NUM_STATS)) begin
            v[s] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/care_scheduler_if.sv
// Request/response bundle between the input front-end (debouncers, LFSR) and the scheduler.
// master drives requests and observes results; slave is the scheduler side.
interface care_scheduler_if;

    logic       enable;
    logic [5:0] btn_req;
    logic       rnd_valid;
    logic [4:0] rnd_stat;
    logic [7:0] care_pulse;
    logic       decay_tick;
    logic [2:0] decay_sel;
    logic [5:0] pending;
    logic       busy;

    modport master (
        output enable, btn_req, rnd_valid, rnd_stat,
        input  care_pulse, decay_tick, decay_sel, pending, busy
    );

    modport slave (
        input  enable, btn_req, rnd_valid, rnd_stat,
        output care_pulse, decay_tick, decay_sel, pending, busy
    );

endinterface

// File: rtl/care_scheduler_rr_arbiter6.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping 5->0.
// Zero latency; any_o low when nothing is requested.
module rr_arbiter6
    import care_scheduler_pkg::*;
(
    input  logic [NUM_STATS-1:0] req_i,
    input  logic [2:0]           ptr_i,
    output logic [2:0]           sel_o,
    output logic                 any_o
);

    logic [2:0] idx;

    always_comb begin
        sel_o = ptr_i;
        any_o = 1'b0;
        idx   = ptr_i;
        for (int k = 0; k < NUM_STATS; k++) begin
            if (!any_o && req_i[idx]) begin
                sel_o = idx;
                any_o = 1'b1;
            end
            idx = stat_inc(idx);
        end
    end

endmodule

// File: rtl/care_scheduler.sv
// Decay-tick divider plus round-robin care grant FSM with cooldown; all outputs registered.
// Request to care pulse is 2 cycles when idle; grants are spaced COOLDOWN+2 cycles apart.
module care_scheduler
    import care_scheduler_pkg::*;
#(
    parameter int unsigned TICK_DIV = 10_000_000,
    parameter int unsigned COOLDOWN = 1_000_000
)
(
    input  logic            clk,
    input  logic            reset,
    care_scheduler_if.slave sch
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [2:0]           nxt_sel_q, nxt_sel_d;
    logic                 decay_tick_q, decay_tick_d;
    logic [2:0]           decay_sel_q, decay_sel_d;
    logic [NUM_STATS-1:0] pending_q, pending_d;

    sched_state_e         state_q;
    logic [CW-1:0]        cd_cnt_q;
    logic [2:0]           rr_ptr_q;
    logic [7:0]           care_pulse_q;
    logic                 busy_q;

    logic                 tick_fire;
    logic [NUM_STATS-1:0] req_set;
    logic [NUM_STATS-1:0] grant_vec;
    logic [2:0]           arb_sel;
    logic                 arb_any;
    logic                 grant_go;

    assign tick_fire = sch.enable && (tick_cnt_q == TW'(TICK_DIV - 1));

    // Tick divider: counter freezes while paused, selector rotates per tick.
    always_comb begin
        tick_cnt_d   = tick_cnt_q;
        nxt_sel_d    = nxt_sel_q;
        decay_tick_d = 1'b0;
        decay_sel_d  = decay_sel_q;
        if (tick_fire) begin
            tick_cnt_d   = '0;
            decay_tick_d = 1'b1;
            decay_sel_d  = nxt_sel_q;
            nxt_sel_d    = stat_inc(nxt_sel_q);
        end else if (sch.enable) begin
            tick_cnt_d = tick_cnt_q + TW'(1);
        end
    end

    always_comb begin
        req_set = sch.btn_req;
        if (sch.rnd_valid && (sch.rnd_stat < 5'(NUM_STATS))) begin
            req_set = req_set | stat_onehot(sch.rnd_stat[2:0]);
        end
    end

    rr_arbiter6 u_arb (
        .req_i (pending_q),
        .ptr_i (rr_ptr_q),
        .sel_o (arb_sel),
        .any_o (arb_any)
    );

    // A grant landing on the same stat as a coinciding decay tick waits one cycle.
    assign grant_go  = (state_q == ST_IDLE) && sch.enable && arb_any &&
                       !(tick_fire && (arb_sel == nxt_sel_q));
    assign grant_vec = grant_go ? stat_onehot(arb_sel) : '0;

    // New requests win over the clear of a bit granted on the same edge.
    assign pending_d = (pending_q & ~grant_vec) | req_set;

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q   <= '0;
            nxt_sel_q    <= STAT_HUNGER;
            decay_tick_q <= 1'b0;
            decay_sel_q  <= STAT_HUNGER;
            pending_q    <= '0;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            nxt_sel_q    <= nxt_sel_d;
            decay_tick_q <= decay_tick_d;
            decay_sel_q  <= decay_sel_d;
            pending_q    <= pending_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cd_cnt_q     <= '0;
            rr_ptr_q     <= STAT_HUNGER;
            care_pulse_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_go) begin
                        state_q      <= ST_GRANT;
                        care_pulse_q <= {2'b00, grant_vec};
                        busy_q       <= 1'b1;
                        rr_ptr_q     <= stat_inc(arb_sel);
                    end
                end
                ST_GRANT: begin
                    care_pulse_q <= '0;
                    cd_cnt_q     <= CW'(COOLDOWN - 1);
                    state_q      <= ST_COOLDOWN;
                end
                ST_COOLDOWN: begin
                    if (cd_cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cd_cnt_q <= cd_cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    care_pulse_q <= '0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign sch.care_pulse = care_pulse_q;
    assign sch.decay_tick = decay_tick_q;
    assign sch.decay_sel  = decay_sel_q;
    assign sch.pending    = pending_q;
    assign sch.busy       = busy_q;

endmodule
